// File: rtl/wb_stage_pkg.sv
// ============================================================================
// Module : wb_stage_pkg
// Desc   : Shared widths, load-op encodings and WB register layout.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package wb_stage_pkg;

  localparam int REG_WIDTH      = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int LOAD_OP_WIDTH  = 3;

  localparam logic [LOAD_OP_WIDTH-1:0] LOAD_NONE = 3'd0;
  localparam logic [LOAD_OP_WIDTH-1:0] LD_B      = 3'd1;
  localparam logic [LOAD_OP_WIDTH-1:0] LD_H      = 3'd2;
  localparam logic [LOAD_OP_WIDTH-1:0] LD_W      = 3'd3;
  localparam logic [LOAD_OP_WIDTH-1:0] LD_BU     = 3'd4;
  localparam logic [LOAD_OP_WIDTH-1:0] LD_HU     = 3'd5;

  typedef struct packed {
    logic                      valid;
    logic                      wen;
    logic [REG_ADDR_WIDTH-1:0] addr;
    logic [REG_WIDTH-1:0]      data;
    logic [LOAD_OP_WIDTH-1:0]  load_op;
    logic [1:0]                byte_off;
    logic                      llbit_we;
    logic                      llbit_value;
  } wb_reg_t;

endpackage

`default_nettype wire

// File: rtl/wb_stage_load_extract.sv
// ============================================================================
// Module : load_extract
// Desc   : Little-endian byte/halfword extraction with sign/zero extension.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module load_extract
  import wb_stage_pkg::*;
(
  input  logic [REG_WIDTH-1:0]     data,
  input  logic [LOAD_OP_WIDTH-1:0] load_op,
  input  logic [1:0]               byte_off,
  output logic [REG_WIDTH-1:0]     result
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte = data[7:0];
    case (byte_off)
      2'd0:    sel_byte = data[7:0];
      2'd1:    sel_byte = data[15:8];
      2'd2:    sel_byte = data[23:16];
      default: sel_byte = data[31:24];
    endcase
    // byte_off[0] is ignored for halfwords; misalignment traps before WB
    sel_half = byte_off[1] ? data[31:16] : data[15:0];
  end

  always_comb begin
    result = data;
    case (load_op)
      LD_B:    result = {{24{sel_byte[7]}}, sel_byte};
      LD_BU:   result = {24'd0, sel_byte};
      LD_H:    result = {{16{sel_half[15]}}, sel_half};
      LD_HU:   result = {16'd0, sel_half};
      default: result = data;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/wb_stage.sv
// ============================================================================
// Module : wb_stage
// Desc   : MEM/WB register, load extraction, LLbit register and regfile port.
//          Optional retire counter enabled by WB_RETIRE_CNT_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module wb_stage
  import wb_stage_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic [5:0]                pause,
  input  logic                      flush,
  input  logic                      mem_valid,
  input  logic                      mem_write_en,
  input  logic [REG_ADDR_WIDTH-1:0] mem_write_addr,
  input  logic [REG_WIDTH-1:0]      mem_write_data,
  input  logic [LOAD_OP_WIDTH-1:0]  mem_load_op,
  input  logic [1:0]                mem_byte_off,
  input  logic                      mem_llbit_we,
  input  logic                      mem_llbit_value,
  output logic                      write_en,
  output logic [REG_ADDR_WIDTH-1:0] write_addr,
  output logic [REG_WIDTH-1:0]      write_data,
  output logic                      llbit
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [63:0]               retire_cnt
`endif
);

  wb_reg_t wb_d, wb_q;
  logic    llbit_d, llbit_q;
  logic    wb_hold;
  logic    wb_llbit_upd;
  logic    unused_pause;

  assign unused_pause = ^pause[3:0];

  assign wb_hold      = !flush && pause[4] && pause[5];
  assign wb_llbit_upd = wb_q.valid && wb_q.llbit_we;

  always_comb begin
    wb_d = wb_q;
    if (flush) begin
      wb_d = '0;
    end else if (pause[4] && !pause[5]) begin
      // MEM stalled but WB free: drain with exactly one bubble per cycle
      wb_d = '0;
    end else if (!pause[4]) begin
      wb_d.valid       = mem_valid;
      wb_d.wen         = mem_write_en;
      wb_d.addr        = mem_write_addr;
      wb_d.data        = mem_write_data;
      wb_d.load_op     = mem_load_op;
      wb_d.byte_off    = mem_byte_off;
      wb_d.llbit_we    = mem_llbit_we;
      wb_d.llbit_value = mem_llbit_value;
    end
  end

  always_comb begin
    llbit_d = llbit_q;
    if (flush) begin
      llbit_d = 1'b0;
    end else if (wb_llbit_upd) begin
      llbit_d = wb_q.llbit_value;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_q    <= '0;
      llbit_q <= 1'b0;
    end else begin
      wb_q    <= wb_d;
      llbit_q <= llbit_d;
    end
  end

  load_extract u_load_extract (
    .data     (wb_q.data),
    .load_op  (wb_q.load_op),
    .byte_off (wb_q.byte_off),
    .result   (write_data)
  );

  assign write_en   = wb_q.valid && wb_q.wen && (wb_q.addr != '0);
  assign write_addr = wb_q.addr;
  // MEM must see an ll.w/sc.w sitting in WB before it lands in the register
  assign llbit      = wb_llbit_upd ? wb_q.llbit_value : llbit_q;

`ifdef WB_RETIRE_CNT_EN
  logic [63:0] retire_cnt_d, retire_cnt_q;

  always_comb begin
    retire_cnt_d = retire_cnt_q;
    if (wb_q.valid && !wb_hold) begin
      retire_cnt_d = retire_cnt_q + 64'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retire_cnt_q <= '0;
    end else begin
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign retire_cnt = retire_cnt_q;
`else
  logic unused_hold;
  assign unused_hold = wb_hold;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wb_stage.sv
// ============================================================================
// Module : tb_wb_stage
// Desc   : Directed scoreboard bench for wb_stage.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_wb_stage;
  import wb_stage_pkg::*;

  logic        clk;
  logic        rst;
  logic [5:0]  pause;
  logic        flush;
  logic        mem_valid;
  logic        mem_write_en;
  logic [4:0]  mem_write_addr;
  logic [31:0] mem_write_data;
  logic [2:0]  mem_load_op;
  logic [1:0]  mem_byte_off;
  logic        mem_llbit_we;
  logic        mem_llbit_value;
  logic        write_en;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic        llbit;
`ifdef WB_RETIRE_CNT_EN
  logic [63:0] retire_cnt;
`endif

  wb_stage dut (
    .clk             (clk),
    .rst             (rst),
    .pause           (pause),
    .flush           (flush),
    .mem_valid       (mem_valid),
    .mem_write_en    (mem_write_en),
    .mem_write_addr  (mem_write_addr),
    .mem_write_data  (mem_write_data),
    .mem_load_op     (mem_load_op),
    .mem_byte_off    (mem_byte_off),
    .mem_llbit_we    (mem_llbit_we),
    .mem_llbit_value (mem_llbit_value),
    .write_en        (write_en),
    .write_addr      (write_addr),
    .write_data      (write_data),
    .llbit           (llbit)
`ifdef WB_RETIRE_CNT_EN
    ,
    .retire_cnt      (retire_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        ll;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc_id   = 0;

  localparam logic [31:0] LW = 32'h80F1_7F82;

  // Monitor: outputs are stable mid-cycle; compare against the oldest expectation
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_checks++;
      if (write_en !== e.we || write_addr !== e.addr ||
          write_data !== e.data || llbit !== e.ll) begin
        n_fail++;
        $display("FAIL cycle%0d: got we=%0b addr=%0d data=%h llbit=%0b, expected we=%0b addr=%0d data=%h llbit=%0b",
                 e.id, write_en, write_addr, write_data, llbit, e.we, e.addr, e.data, e.ll);
      end
    end
  end

  task automatic expect_out(input logic we, input logic [4:0] a,
                            input logic [31:0] d, input logic ll);
    exp_t e;
    e.id = cyc_id; e.we = we; e.addr = a; e.data = d; e.ll = ll;
    exp_q.push_back(e);
  endtask

  // One cycle: drive MEM inputs for this cycle, push the outputs expected during it
  task automatic cyc(input logic v, input logic we, input logic [4:0] a,
                     input logic [31:0] d, input logic [2:0] op, input logic [1:0] off,
                     input logic lwe, input logic lval, input logic [5:0] p, input logic f,
                     input logic ewe, input logic [4:0] ea, input logic [31:0] ed,
                     input logic ell);
    mem_valid = v; mem_write_en = we; mem_write_addr = a; mem_write_data = d;
    mem_load_op = op; mem_byte_off = off; mem_llbit_we = lwe; mem_llbit_value = lval;
    pause = p; flush = f;
    expect_out(ewe, ea, ed, ell);
    cyc_id++;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b0;
    pause = '0; flush = 1'b0;
    mem_valid = 1'b0; mem_write_en = 1'b0; mem_write_addr = '0; mem_write_data = '0;
    mem_load_op = '0; mem_byte_off = '0; mem_llbit_we = 1'b0; mem_llbit_value = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 3; i++) begin
      mem_valid = 1'b1; mem_write_en = 1'b1;
      mem_write_addr = 5'($urandom_range(1, 31)); mem_write_data = $urandom;
      mem_load_op = 3'($urandom); mem_byte_off = 2'($urandom);
      mem_llbit_we = 1'b1; mem_llbit_value = 1'b1;
      pause = '0; flush = 1'b0;
      expect_out(1'b0, 5'd0, 32'd0, 1'b0);
      cyc_id++;
      @(posedge clk); #1;
    end

    rst = 1'b1;
    //   v  we addr  data          op         off   lwe lval pause       fl   exp: we addr data          ll
    cyc(1, 1, 5'd5,  LW,           LD_B,      2'd0, 0, 0, 6'b000000, 0,  0, 5'd0,  32'h0000_0000, 0);
    cyc(1, 1, 5'd5,  LW,           LD_BU,     2'd3, 0, 0, 6'b000000, 0,  1, 5'd5,  32'hFFFF_FF82, 0);
    cyc(1, 1, 5'd5,  LW,           LD_H,      2'd2, 0, 0, 6'b000000, 0,  1, 5'd5,  32'h0000_0080, 0);
    cyc(1, 1, 5'd5,  LW,           LD_HU,     2'd0, 0, 0, 6'b000000, 0,  1, 5'd5,  32'hFFFF_80F1, 0);
    cyc(1, 1, 5'd6,  LW,           LD_W,      2'd1, 0, 0, 6'b000000, 0,  1, 5'd5,  32'h0000_7F82, 0);
    cyc(1, 1, 5'd0,  32'h1234,     LOAD_NONE, 2'd0, 0, 0, 6'b000000, 0,  1, 5'd6,  LW,            0);
    // MEM-only stall: single bubble
    cyc(1, 1, 5'd7,  32'h1111_1111, LOAD_NONE, 2'd0, 0, 0, 6'b010000, 0, 0, 5'd0,  32'h0000_1234, 0);
    cyc(1, 1, 5'd7,  32'h1111_1111, LOAD_NONE, 2'd0, 0, 0, 6'b000000, 0, 0, 5'd0,  32'h0000_0000, 0);
    // MEM+WB stall: held
    cyc(1, 1, 5'd8,  32'h2222_2222, LOAD_NONE, 2'd0, 0, 0, 6'b110000, 0, 1, 5'd7,  32'h1111_1111, 0);
    cyc(1, 1, 5'd8,  32'h2222_2222, LOAD_NONE, 2'd0, 0, 0, 6'b110000, 0, 1, 5'd7,  32'h1111_1111, 0);
    cyc(1, 1, 5'd8,  32'h2222_2222, LOAD_NONE, 2'd0, 0, 0, 6'b000000, 0, 1, 5'd7,  32'h1111_1111, 0);
    // LLbit: ll.w, plain, sc.w, ll.w
    cyc(1, 1, 5'd9,  32'h3333_3333, LOAD_NONE, 2'd0, 1, 1, 6'b000000, 0, 1, 5'd8,  32'h2222_2222, 0);
    cyc(1, 1, 5'd10, 32'h0000_0044, LOAD_NONE, 2'd0, 0, 0, 6'b000000, 0, 1, 5'd9,  32'h3333_3333, 1);
    cyc(1, 1, 5'd11, 32'h0000_0001, LOAD_NONE, 2'd0, 1, 0, 6'b000000, 0, 1, 5'd10, 32'h0000_0044, 1);
    cyc(1, 1, 5'd12, 32'h0000_0055, LOAD_NONE, 2'd0, 1, 1, 6'b000000, 0, 1, 5'd11, 32'h0000_0001, 0);
    cyc(1, 1, 5'd13, 32'h0000_0066, LOAD_NONE, 2'd0, 0, 0, 6'b000000, 0, 1, 5'd12, 32'h0000_0055, 1);
    cyc(1, 1, 5'd14, 32'h0000_0077, LOAD_NONE, 2'd0, 0, 0, 6'b000000, 0, 1, 5'd13, 32'h0000_0066, 1);
    // Flush with LLbit=1: current write still happens, then bubble, LLbit cleared
    cyc(1, 1, 5'd15, 32'h0000_00EE, LOAD_NONE, 2'd0, 0, 0, 6'b000000, 1, 1, 5'd14, 32'h0000_0077, 1);
    cyc(1, 1, 5'd16, 32'h0000_0088, LOAD_NONE, 2'd0, 1, 1, 6'b000000, 0, 0, 5'd0,  32'h0000_0000, 0);
    // Flush coinciding with a WB ll.w: bypass shows 1, register ends 0
    cyc(1, 1, 5'd17, 32'h0000_0099, LOAD_NONE, 2'd0, 0, 0, 6'b000000, 1, 1, 5'd16, 32'h0000_0088, 1);
    cyc(0, 1, 5'd18, 32'h0000_00AA, LOAD_NONE, 2'd0, 0, 0, 6'b000000, 0, 0, 5'd0,  32'h0000_0000, 0);
    cyc(1, 0, 5'd19, 32'h0000_00BB, LOAD_NONE, 2'd0, 0, 0, 6'b000000, 0, 0, 5'd18, 32'h0000_00AA, 0);
    cyc(0, 0, 5'd0,  32'h0000_0000, LOAD_NONE, 2'd0, 0, 0, 6'b000000, 0, 0, 5'd19, 32'h0000_00BB, 0);
    cyc(0, 0, 5'd0,  32'h0000_0000, LOAD_NONE, 2'd0, 0, 0, 6'b000000, 0, 0, 5'd0,  32'h0000_0000, 0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

`ifdef WB_RETIRE_CNT_EN
    #1;
    n_checks++;
    if (retire_cnt !== 64'd16) begin
      n_fail++;
      $display("FAIL retire_cnt: got %0d, expected 16", retire_cnt);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
